hist_uart_streamer: RTL
=======================

HIST_UART_STREAMER -- requirements
Module: hist_uart_streamer

Interface
REQ-001 Parameter NUM_BINS, default 90: number of histogram entries read out per dump.
REQ-002 Parameter HIST_DATA_W, default 32: width of one histogram counter, 8..32.
REQ-003 Parameter CLK_DIV, default 868: clk cycles per UART bit, minimum 4.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 freeze  input  1  histogram frozen; its rising edge starts a dump.
REQ-007 hist_data  input  HIST_DATA_W  counter value for index hist_rd_idx (combinational upstream mux).
REQ-008 hist_rd_idx  output  $clog2(NUM_BINS)  registered bin index requested from the histogram.
REQ-009 uart_tx  output  1  UART 8N1 serial line, idle high.
REQ-010 busy  output  1  high from dump start until the last stop bit completes.
REQ-011 done  output  1  high after a completed dump, until freeze falls.

Function
REQ-012 FSM states: IDLE, HDR, SETIDX, LATCH, SEND, TRL, DONE.
REQ-013 IDLE -> HDR on a freeze rising edge; freeze held high out of reset is not an edge.
REQ-014 HDR sends header byte 0xA5, then -> SETIDX with hist_rd_idx=0.
REQ-015 SETIDX holds hist_rd_idx stable one cycle; LATCH captures hist_data into the shift register in the following cycle (2-cycle read latency).
REQ-016 SEND transmits the index byte, then ceil(HIST_DATA_W/8) data bytes little-endian, zero-padded in the upper bits.
REQ-017 After the last byte of a bin: if hist_rd_idx==NUM_BINS-1 -> TRL, else increment hist_rd_idx and -> SETIDX.
REQ-018 TRL sends trailer byte 0x5A (plus the checksum byte per REQ-027), then -> DONE.
REQ-019 DONE: done=1, busy=0; -> IDLE when freeze==0, which clears done.
REQ-020 Byte framing: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLK_DIV cycles; the next byte starts no earlier than the cycle after the stop bit ends.
REQ-021 freeze falling mid-dump is ignored; the dump completes, then the FSM passes through DONE to IDLE.
REQ-022 A freeze rising edge while busy or in DONE is ignored.
REQ-023 Total line time per dump is (2 + NUM_BINS*(1+ceil(HIST_DATA_W/8)) [+1 with checksum]) * 10 * CLK_DIV cycles, plus per-byte handoff gaps of at most 3 cycles.

Reset
REQ-024 Asynchronous reset forces: uart_tx=1, busy=0, done=0, hist_rd_idx=0, FSM=IDLE, baud counter=0.
REQ-025 Reset asserted mid-byte aborts the frame and drives uart_tx high the same instant; there is no resume.
REQ-026 Release of reset with freeze already high does not start a dump.

Configuration
REQ-027 With HIST_STREAM_CHECKSUM_EN defined: a running XOR of every byte after the header, through the trailer inclusive, is sent as one extra byte after 0x5A.
REQ-028 Without HIST_STREAM_CHECKSUM_EN: no checksum logic, and the frame ends at 0x5A.

Structure
REQ-029 Package hist_stream_pkg holds HDR_BYTE=8'hA5, TRL_BYTE=8'h5A and the FSM state enum typedef.
REQ-030 Sub-module uart_tx_byte: 8N1 serializer with inputs data[7:0], start, and outputs tx, ready; parameter CLK_DIV.
REQ-031 hist_uart_streamer owns sequencing only; uart_tx_byte owns all bit timing.

Verification
REQ-032 NUM_BINS=3, HIST_DATA_W=32, CLK_DIV=4, hist_data=idx+0x01020300, freeze rise -> bytes A5 00 00 03 02 01 01 01 03 02 01 02 02 03 02 01 5A; done=1.
REQ-033 Same setup with HIST_STREAM_CHECKSUM_EN -> identical bytes followed by the XOR of bytes 2..17.
REQ-034 Bit timing: every bit is 4 cycles, the start bit is low and the stop bit is high; idle line is high before the dump and after it.
REQ-035 reset_n pulsed low during byte 5 -> uart_tx=1 and busy=0 at once; after release with freeze high -> no output until freeze toggles 0->1.
REQ-036 freeze dropped during bin 1 -> dump completes with all 17 bytes, done pulses, then -> IDLE; a second freeze rise produces an identical dump.
REQ-037 HIST_DATA_W=12, hist_data=12'hABC -> data bytes BC 0A (two bytes, upper bits zero).

Source files
------------

// File: rtl/hist_stream_pkg.sv
// Shared constants and types for the histogram UART streamer.
// The optional HIST_STREAM_CHECKSUM_EN build adds a trailing XOR byte.
package hist_stream_pkg;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] TRL_BYTE = 8'h5A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        SETIDX = 3'd2,
        LATCH  = 3'd3,
        SEND   = 3'd4,
        TRL    = 3'd5,
        DONE   = 3'd6
    } state_t;

    // Number of little-endian bytes needed to carry one histogram counter.
    function automatic int bytes_per_bin(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer. A byte is accepted when start is high while
// ready is high; the line then carries start bit, 8 data bits LSB first and
// a stop bit, each exactly CLK_DIV clk cycles. ready returns high in the
// cycle after the stop bit has ended.
module uart_tx_byte #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       ready
);

    localparam int               CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [3:0]       STOP_BIT  = 4'd9;

    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_shift;
    logic             r_active;
    logic             r_tx;

    // Bit timing: load a frame on start, then step one bit every CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 9'h1FF;
            r_active   <= 1'b0;
            r_tx       <= 1'b1;
        end else if (!r_active) begin
            if (start) begin
                r_active   <= 1'b1;
                r_tx       <= 1'b0;
                r_shift    <= {1'b1, data};
                r_bit_cnt  <= 4'd0;
                r_baud_cnt <= '0;
            end
        end else if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == STOP_BIT) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

    assign tx    = r_tx;
    assign ready = ~r_active;

endmodule

// File: rtl/hist_uart_streamer.sv
// Histogram dump sequencer: on a rising edge of freeze, reads every bin of
// an external histogram and streams header, (index, counter bytes) per bin
// and trailer over an 8N1 UART. Bit timing lives entirely in uart_tx_byte.
// Define HIST_STREAM_CHECKSUM_EN to append an XOR checksum byte covering all
// bytes after the header up to and including the trailer.
module hist_uart_streamer
    import hist_stream_pkg::*;
#(
    parameter int NUM_BINS    = 90,
    parameter int HIST_DATA_W = 32,
    parameter int CLK_DIV     = 868
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    freeze,
    input  logic [HIST_DATA_W-1:0]  hist_data,
    output logic [((NUM_BINS > 1) ? $clog2(NUM_BINS) : 1)-1:0] hist_rd_idx,
    output logic                    uart_tx,
    output logic                    busy,
    output logic                    done
);

    localparam int               IDX_W     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int               NBYTES    = bytes_per_bin(HIST_DATA_W);
    localparam int               SH_W      = NBYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BINS - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(NBYTES);
`ifdef HIST_STREAM_CHECKSUM_EN
    localparam logic [2:0]       TRL_LAST  = 3'd1;
`else
    localparam logic [2:0]       TRL_LAST  = 3'd0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic             r_freeze_d;
    logic             w_freeze_rise;
    logic [IDX_W-1:0] r_idx;
    logic [SH_W-1:0]  r_data;
    logic [2:0]       r_byte_cnt;
    logic             r_issued;
    logic             r_busy;
    logic             r_done;
    logic             w_tx_start;
    logic [7:0]       w_tx_data;
    logic             w_tx_ready;
    logic             w_byte_done;
`ifdef HIST_STREAM_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    // Freeze held high out of reset looks like "already high", so it is no edge.
    assign w_freeze_rise = freeze & ~r_freeze_d;
    // A byte is finished once it was handed over and the serializer is free again.
    assign w_byte_done   = r_issued & w_tx_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and byte selection for the serializer.
    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_freeze_rise) begin
                    w_next = HDR;
                end else begin
                    w_next = IDLE;
                end
            end
            HDR: begin
                w_tx_data = HDR_BYTE;
                if (!r_issued) begin
                    w_tx_start = w_tx_ready;
                end else if (w_tx_ready) begin
                    w_next = SETIDX;
                end else begin
                    w_next = HDR;
                end
            end
            SETIDX: begin
                w_next = LATCH;
            end
            LATCH: begin
                w_next = SEND;
            end
            SEND: begin
                if (r_byte_cnt == 3'd0) begin
                    w_tx_data = 8'(r_idx);
                end else begin
                    w_tx_data = r_data[7:0];
                end
                if (!r_issued) begin
                    w_tx_start = w_tx_ready;
                end else if (w_tx_ready && (r_byte_cnt == LAST_BYTE)) begin
                    if (r_idx == LAST_IDX) begin
                        w_next = TRL;
                    end else begin
                        w_next = SETIDX;
                    end
                end else begin
                    w_next = SEND;
                end
            end
            TRL: begin
`ifdef HIST_STREAM_CHECKSUM_EN
                if (r_byte_cnt == 3'd0) begin
                    w_tx_data = TRL_BYTE;
                end else begin
                    w_tx_data = r_csum;
                end
`else
                w_tx_data = TRL_BYTE;
`endif
                if (!r_issued) begin
                    w_tx_start = w_tx_ready;
                end else if (w_tx_ready && (r_byte_cnt == TRL_LAST)) begin
                    w_next = DONE;
                end else begin
                    w_next = TRL;
                end
            end
            DONE: begin
                if (!freeze) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: bin index, counter shift register, byte handshake and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_freeze_d <= 1'b1;
            r_idx      <= '0;
            r_data     <= '0;
            r_byte_cnt <= 3'd0;
            r_issued   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_freeze_d <= freeze;

            if (w_tx_start) begin
                r_issued <= 1'b1;
            end else if (w_byte_done) begin
                r_issued <= 1'b0;
            end

            if (w_byte_done) begin
                r_byte_cnt <= (w_next != r_state) ? 3'd0 : (r_byte_cnt + 3'd1);
            end

            if (r_state == IDLE) begin
                r_idx <= '0;
            end else if ((r_state == SEND) && (w_next == SETIDX)) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            if (r_state == LATCH) begin
                r_data <= SH_W'(hist_data);
            end else if ((r_state == SEND) && w_byte_done && (r_byte_cnt != 3'd0)) begin
                r_data <= r_data >> 32'd8;
            end

            r_busy <= (w_next != IDLE) && (w_next != DONE);
            r_done <= (w_next == DONE);
        end
    end

`ifdef HIST_STREAM_CHECKSUM_EN
    // Running XOR over every byte after the header, trailer included.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csum <= 8'h00;
        end else if (r_state == IDLE) begin
            r_csum <= 8'h00;
        end else if (w_tx_start && (r_state != HDR) &&
                     !((r_state == TRL) && (r_byte_cnt != 3'd0))) begin
            r_csum <= r_csum ^ w_tx_data;
        end
    end
`endif

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .data    (w_tx_data),
        .start   (w_tx_start),
        .tx      (uart_tx),
        .ready   (w_tx_ready)
    );

    assign hist_rd_idx = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
